fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_controller_if.sv | 15 +
 rtl/fetch_controller_flush_counter.sv | 18 +
 rtl/fetch_controller.sv | 88 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch controller.
package fetch_pkg;
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } state_t;
    localparam int PC_INC = 4;
    localparam int CNT_W = 3;
    localparam int PERF_W = 32;
endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: pipeline-facing signals of the fetch controller.
interface fetch_controller_if #(parameter int B = 32);
    logic [B-1:0] pc_cur, branch_target, pc_next;
    logic branch_taken, stall, halt, resume;
    logic pc_write, ifid_write, ifid_flush, halted;
    logic [2:0] fsm_state;
    modport master (
        input  pc_cur, branch_taken, branch_target, stall, halt, resume,
        output pc_next, pc_write, ifid_write, ifid_flush, halted, fsm_state
    );
    modport slave (
        output pc_cur, branch_taken, branch_target, stall, halt, resume,
        input  pc_next, pc_write, ifid_write, ifid_flush, halted, fsm_state
    );
endinterface

// File: rtl/fetch_controller_flush_counter.sv
// flush_counter: loadable down-counter with hold and zero flag.
module flush_counter
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             dec,
    input  logic [CNT_W-1:0] ld_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    assign zero = cnt == '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (ld) cnt <= ld_val;
        else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC/IF-ID control FSM (boot, redirect flush, stall, halt).
// FETCH_PERF_COUNTERS_EN adds saturating stall/flush cycle counters.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int           B           = 32,
    parameter int           FLUSH_SLOTS = 1,
    parameter logic [B-1:0] RESET_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_controller_if.master bus
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [PERF_W-1:0] stall_count,
    output logic [PERF_W-1:0] flush_count
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FLUSH_SLOTS - 1);
    state_t state, nxt, ret;
    logic ld, dec, zero;
    logic [CNT_W-1:0] cnt;
    logic [B-1:0] pc_inc;
    assign pc_inc = bus.pc_cur + B'(PC_INC);
    assign bus.fsm_state = state;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= BOOT;
        else state <= nxt;
    // RUN always holds a zero counter and FLUSH a nonzero one, so STALL recovers its origin from it
    always_comb begin
        nxt = state;
        ld = 1'b0;
        dec = 1'b0;
        bus.pc_write = 1'b0;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b1;
        bus.halted = 1'b0;
        bus.pc_next = pc_inc;
        ret = state == STALL ? (zero ? RUN : FLUSH) : state;
        if (state == BOOT) begin
            bus.pc_next = RESET_ADDR;
            nxt = RUN;
        end else if (state == HALT) begin
            bus.halted = 1'b1;
            nxt = bus.resume ? RUN : HALT;
        end else if (bus.branch_taken) begin
            bus.pc_write = 1'b1;
            bus.pc_next = bus.branch_target;
            ld = 1'b1;
            nxt = LAST == '0 ? RUN : FLUSH;
        end else if (bus.halt) begin
            ld = 1'b1;
            nxt = HALT;
        end else if (bus.stall) begin
            bus.ifid_write = 1'b0;
            bus.ifid_flush = 1'b0;
            nxt = STALL;
        end else if (ret == FLUSH) begin
            bus.pc_write = 1'b1;
            dec = 1'b1;
            nxt = cnt == CNT_W'(1) ? RUN : FLUSH;
        end else begin
            bus.pc_write = 1'b1;
            bus.ifid_flush = 1'b0;
            nxt = RUN;
        end
    end
    flush_counter u_cnt (
        .clk    (clk),
        .reset  (reset),
        .ld     (ld),
        .dec    (dec),
        .ld_val (bus.halt && !bus.branch_taken ? '0 : LAST),
        .cnt    (cnt),
        .zero   (zero)
    );
`ifdef FETCH_PERF_COUNTERS_EN
    // ifid_write is low only in cycles with stall behaviour
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!bus.ifid_write && ~&stall_count) stall_count <= stall_count + 1'b1;
            if (bus.ifid_flush && ~&flush_count) flush_count <= flush_count + 1'b1;
        end
`endif
endmodule
